// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] instr_index_t;

endpackage

// File: rtl/frame_checksum.sv
// Running XOR over the frame bytes between SYNC and CHK.
module frame_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] result
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear)       acc_d = 8'h00;
    else if (enable) acc_d = acc_q ^ data_in;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= 8'h00;
    else       acc_q <= acc_d;
  end

  assign result = acc_q;

endmodule

// File: rtl/program_loader.sv
// Frame parser that turns a SYNC/LEN/DATA/CHK byte stream into halfword writes
// on the CPU program download port.
module program_loader
  import loader_pkg::*;
#(
  parameter instr_index_t START_INDEX = '0,
  parameter int unsigned  MAX_WORDS   = 1024,
  parameter logic [7:0]   SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        prog_we,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  state_e       state_q, state_d;
  logic [15:0]  len_q, len_d;
  logic [7:0]   lo_q, lo_d;
  logic         download_q, download_d;
  instr_index_t index_q, index_d;
  halfword_t    prog_q, prog_d;
  logic         we_q, we_d;
  logic         done_q, done_d;
  logic         error_q, error_d;
  logic [15:0]  words_q, words_d;

  logic         accept;
  logic         chk_clear, chk_en;
  logic [7:0]   chk_result;
  logic [15:0]  len_full;

  // Ready is a function of state only, so it never loops back through byte_valid.
  assign byte_ready = (state_q != S_DONE);
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {byte_data, len_q[7:0]};

  frame_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .clear   (chk_clear),
    .enable  (chk_en),
    .data_in (byte_data),
    .result  (chk_result)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    lo_d       = lo_q;
    download_d = download_q;
    index_d    = index_q;
    prog_d     = prog_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;
    words_d    = words_q;
    chk_clear  = 1'b0;
    chk_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept && byte_data == SYNC_BYTE) begin
          state_d    = S_LEN_LO;
          error_d    = 1'b0;
          words_d    = '0;
          chk_clear  = 1'b1;
          download_d = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          chk_en     = 1'b1;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d  = len_full;
          chk_en = 1'b1;
          if (len_full == '0) begin
            state_d = S_CHECK;
          end else if (32'(len_full) > MAX_WORDS) begin
            error_d    = 1'b1;
            download_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = byte_data;
          chk_en  = 1'b1;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          chk_en  = 1'b1;
          prog_d  = {byte_data, lo_q};
          index_d = START_INDEX + instr_index_t'(words_q);
          we_d    = 1'b1;
          words_d = words_q + 16'd1;
          state_d = (words_d < len_q) ? S_DATA_LO : S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (chk_result == byte_data) done_d  = 1'b1;
          else                         error_d = 1'b1;
          download_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      lo_q       <= '0;
      download_q <= 1'b0;
      index_q    <= START_INDEX;
      prog_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      lo_q       <= lo_d;
      download_q <= download_d;
      index_q    <= index_d;
      prog_q     <= prog_d;
      we_q       <= we_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
    end
  end

  assign download_program  = download_q;
  assign instruction_index = index_q;
  assign program_in        = prog_q;
  assign prog_we           = we_q;
  assign load_done         = done_q;
  assign load_error        = error_q;
  assign words_loaded      = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames are
// built and popped whenever the loader strobes prog_we.
module tb_program_loader;

  localparam logic [31:0] START = 32'd10;

  typedef struct {
    logic [31:0] idx;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        download_program;
  logic [31:0] instruction_index;
  logic [15:0] program_in;
  logic        prog_we;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  program_loader #(
    .START_INDEX (START),
    .MAX_WORDS   (4),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .download_program  (download_program),
    .instruction_index (instruction_index),
    .program_in        (program_in),
    .prog_we           (prog_we),
    .load_done         (load_done),
    .load_error        (load_error),
    .words_loaded      (words_loaded)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          done_total = 0;
  int          done_base = 0;
  logic        rdy_seen;
  wr_t         exp_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe outputs at the falling edge, then return just after the next rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    rdy_seen = byte_ready;
    if (prog_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("we_spurious", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_index", instruction_index, e.idx);
        check("we_data", 32'(program_in), 32'(e.data));
      end
    end
    if (load_done === 1'b1) done_total++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick();
      ok = rdy_seen;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_q(input int gap_max);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_byte(b);
    end
  endtask

  // Builds a well-formed frame from words[] and queues its expected writes.
  task automatic make_frame();
    logic [7:0] chk = 8'h00;
    logic [15:0] n;
    n = 16'(words.size());
    tx_q = {};
    tx_q.push_back(8'hA5);
    tx_q.push_back(n[7:0]);  chk ^= n[7:0];
    tx_q.push_back(n[15:8]); chk ^= n[15:8];
    for (int k = 0; k < words.size(); k++) begin
      tx_q.push_back(words[k][7:0]);  chk ^= words[k][7:0];
      tx_q.push_back(words[k][15:8]); chk ^= words[k][15:8];
      exp_q.push_back('{idx: START + 32'(k), data: words[k]});
    end
    tx_q.push_back(chk);
  endtask

  task automatic end_check(input string tag, input int exp_done, input logic exp_err,
                           input int exp_words);
    idle(3);
    check({tag, "_done_cnt"}, 32'(done_total - done_base), 32'(exp_done));
    check({tag, "_error"}, 32'(load_error), 32'(exp_err));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_download"}, 32'(download_program), 32'd0);
    check({tag, "_pending_wr"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_download"}, 32'(download_program), 32'd0);
    check({tag, "_index"}, instruction_index, START);
    check({tag, "_prog_in"}, 32'(program_in), 32'd0);
    check({tag, "_we"}, 32'(prog_we), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Basic two-word frame, handshake-level checks around SYNC and DONE.
    done_base = done_total;
    exp_q.push_back('{idx: 32'd10, data: 16'h2005});
    exp_q.push_back('{idx: 32'd11, data: 16'h1FC2});
    send_byte(8'hA5);
    check("s1_download_hi", 32'(download_program), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h20);
    send_byte(8'hC2); send_byte(8'h1F);
    check("s1_download_mid", 32'(download_program), 32'd1);
    send_byte(8'hFA);
    check("s1_done_ready", 32'(byte_ready), 32'd0);
    check("s1_done_pulse", 32'(load_done), 32'd1);
    check("s1_done_dl", 32'(download_program), 32'd0);
    end_check("s1", 1, 1'b0, 2);
    check("s1_index_hold", instruction_index, 32'd11);
    check("s1_prog_hold", 32'(program_in), 32'h1FC2);

    // Bad checksum: data still written, error instead of done.
    done_base = done_total;
    exp_q.push_back('{idx: 32'd10, data: 16'h2005});
    exp_q.push_back('{idx: 32'd11, data: 16'h1FC2});
    tx_q = {8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'h00};
    send_q(0);
    end_check("s2", 0, 1'b1, 2);

    // Zero-length frame.
    done_base = done_total;
    tx_q = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_q(0);
    end_check("s3", 1, 1'b0, 0);

    // Oversized length, trailing bytes discarded, then a good frame recovers.
    done_base = done_total;
    tx_q = {8'hA5, 8'h05, 8'h00};
    send_q(0);
    check("s4_err_now", 32'(load_error), 32'd1);
    check("s4_dl_low", 32'(download_program), 32'd0);
    tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
    send_q(0);
    check("s4_err_sticky", 32'(load_error), 32'd1);
    check("s4_dl_still_low", 32'(download_program), 32'd0);
    send_byte(8'hA5);
    check("s4_err_cleared", 32'(load_error), 32'd0);
    exp_q.push_back('{idx: 32'd10, data: 16'h1234});
    tx_q = {8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
    send_q(0);
    end_check("s4", 1, 1'b0, 1);

    // Leading garbage plus random valid gaps.
    done_base = done_total;
    exp_q.push_back('{idx: 32'd10, data: 16'h2005});
    exp_q.push_back('{idx: 32'd11, data: 16'h1FC2});
    tx_q = {8'h11, 8'h22, 8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
    send_q(3);
    end_check("s5", 1, 1'b0, 2);

    // Length exactly MAX_WORDS is accepted.
    done_base = done_total;
    words = {16'h1111, 16'hBEEF, 16'h0000, 16'hFFFF};
    make_frame();
    send_q(2);
    end_check("s6", 1, 1'b0, 4);

    // Reset after the first halfword of a two-word frame.
    done_base = done_total;
    exp_q.push_back('{idx: 32'd10, data: 16'h2005});
    tx_q = {8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2};
    send_q(0);
    byte_valid = 1'b1;
    byte_data  = 8'h1F;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("s7");
    idle(4);
    check("s7_pending_wr", 32'(exp_q.size()), 32'd0);
    check("s7_done_cnt", 32'(done_total - done_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader directly upstream of the CPU's program download port.
- Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 16-bit Thumb halfwords and drives download_program, instruction_index and program_in, writing one halfword per write strobe into consecutive instruction slots.
- Checks frame length and an XOR checksum, and reports done or error.

Parameters:
- START_INDEX, 0: instruction_index of the first halfword in a frame.
- MAX_WORDS, 1024: largest halfword count accepted; larger counts are rejected.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
- download_program  out  1  high for the whole frame; holds the CPU in load mode.
- instruction_index  out  32  target slot of program_in.
- program_in  out  16  assembled halfword.
- prog_we  out  1  one-cycle strobe; program_in and instruction_index are valid while it is high.
- load_done  out  1  one-cycle pulse on a good frame end.
- load_error  out  1  sticky error flag; cleared on the next accepted SYNC_BYTE.
- words_loaded  out  16  halfwords written in the current or last frame.

Behaviour:
- Reset values: state IDLE; byte_ready 1; download_program 0; instruction_index START_INDEX; program_in 0; prog_we 0; load_done 0; load_error 0; words_loaded 0. Reset mid-frame aborts the frame immediately; halfwords already written are not undone.
- Frame format: SYNC, LEN_LO, LEN_HI, then 2*LEN data bytes (lo, hi per halfword), then CHK.
  - CHK = XOR of every byte after SYNC, up to and excluding CHK.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE. All state transitions happen only on an accepted byte, except DONE.
- IDLE:
  - Accepted SYNC_BYTE -> LEN_LO; clear load_error, words_loaded and the checksum accumulator; download_program = 1 from the next cycle.
  - Any other byte is discarded.
- LEN_LO -> LEN_HI.
- LEN_HI:
  - LEN = 0 -> CHECK.
  - LEN > MAX_WORDS -> load_error = 1, download_program = 0 next cycle, go to IDLE. The remaining bytes are then discarded as non-sync bytes, unless one equals SYNC_BYTE, in which case a new frame starts.
  - Otherwise -> DATA_LO.
- DATA_LO: latch the low byte -> DATA_HI.
- DATA_HI, on an accepted byte at cycle t:
  - At t+1: program_in = {hi, lo}, instruction_index = START_INDEX + k (k = halfword number from 0), prog_we = 1 for exactly one cycle, words_loaded = k+1.
  - -> DATA_LO if k+1 < LEN, else CHECK.
- CHECK, on an accepted byte:
  - Match -> load_done pulses next cycle.
  - Mismatch -> load_error = 1.
  - Either way -> DONE.
- DONE: lasts exactly one cycle. byte_ready = 0, download_program = 0 on that cycle, then -> IDLE.
- byte_ready is 1 in every state except DONE. It never depends combinationally on byte_valid.
- After a frame, instruction_index and program_in hold their last values.
- Index arithmetic is 32-bit with no wrap checks; START_INDEX + MAX_WORDS - 1 must fit in 32 bits.
- byte_valid with byte_ready low: the byte is not consumed, and upstream holds it.
- No timeout. A stalled frame keeps download_program high until it completes or reset.

Decomposition:
- Shared package loader_pkg holds:
  - state enum typedef;
  - SYNC_BYTE default;
  - halfword_t (16-bit);
  - instr_index_t (32-bit).
- One natural sub-module: frame_checksum. It is an XOR accumulator with clear and enable inputs and an 8-bit result.
- Everything else lives in one FSM module.

Test Plan:
- START_INDEX = 10. Bytes A5 02 00 05 20 C2 1F FA -> prog_we pulses twice with (index 10, 0x2005) and (index 11, 0x1FC2), then load_done = 1, load_error = 0, words_loaded = 2, download_program falls after DONE.
- Same frame with CHK = 00 -> both halfwords still written; load_error = 1; no load_done pulse.
- Frame A5 00 00 00 (zero length) -> no prog_we; load_done pulses; words_loaded = 0.
- MAX_WORDS = 4, frame A5 05 00 ... -> load_error = 1 after LEN_HI; download_program = 0; a following good frame clears load_error and loads normally.
- Garbage 11 22 before A5, plus random byte_valid gaps inside the frame -> garbage ignored; same writes and indices as the first scenario.
- Reset asserted after the first halfword of a two-word frame -> all outputs return to reset values the next cycle; second halfword never written.
